// File: rtl/pj_bus_pkg.sv
// Shared encodings for the picoJava-II external bus monitor: field codes,
// monitor state and sticky error-flag bit positions.
package pj_bus_pkg;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_BURST = 2'b11;

  localparam logic [1:0] ACK_WAIT   = 2'b00;
  localparam logic [1:0] ACK_OK     = 2'b01;
  localparam logic [1:0] ACK_MEMERR = 2'b10;
  localparam logic [1:0] ACK_IOERR  = 2'b11;

  localparam int TYPE_WRITE = 0;
  localparam int TYPE_IFETCH = 1;
  localparam int TYPE_NONCACHE = 2;
  localparam int TYPE_RSVD = 3;

  localparam int ERR_W         = 6;
  localparam int ERR_TV_BUSY   = 0;
  localparam int ERR_ACK_IDLE  = 1;
  localparam int ERR_TIMEOUT   = 2;
  localparam int ERR_RSVD_TYPE = 3;
  localparam int ERR_BURST_WR  = 4;
  localparam int ERR_STANDBY   = 5;

  localparam logic [2:0] BURST_BEATS = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mon_state_e;

  // Both error acknowledge codes have bit 1 set.
  function automatic logic is_err_ack(input logic [1:0] ack);
    return ack[1];
  endfunction

endpackage

// File: rtl/pj_sat_counter.sv
// Saturating up-counter used for the monitor's read/write/error statistics.
module pj_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pj_bus_monitor.sv
// Passive picoJava-II memory bus checker: tracks one outstanding request,
// reports each completion, flags protocol violations and counts traffic.
module pj_bus_monitor
  import pj_bus_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pj_tv,
  input  logic [3:0]       pj_type,
  input  logic [1:0]       pj_size,
  input  logic [1:0]       pj_ack,
  input  logic [29:0]      pj_address,
  input  logic [31:0]      pj_data_in,
  input  logic [31:0]      pj_data_out,
  input  logic             pj_standby_out,
  output logic             txn_done,
  output logic [29:0]      txn_addr,
  output logic [3:0]       txn_type,
  output logic [1:0]       txn_size,
  output logic [31:0]      txn_data,
  output logic             txn_err,
  output logic [5:0]       err_flags,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] errack_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  mon_state_e       state_q, state_d;
  logic [2:0]       beats_q, beats_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [29:0] addr_q;
  logic [3:0]  type_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        done_q;
  logic [29:0] taddr_q;
  logic [3:0]  ttype_q;
  logic [1:0]  tsize_q;
  logic [31:0] tdata_q;
  logic        terr_q;

  logic        cap_req, cap_rd;
  logic        complete, cmpl_err, errack_inc;
  logic [31:0] cmpl_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beats_q <= '0;
      wait_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beats_d    = beats_q;
    wait_d     = wait_q;
    err_d      = err_q;
    cap_req    = 1'b0;
    cap_rd     = 1'b0;
    complete   = 1'b0;
    cmpl_err   = 1'b0;
    errack_inc = 1'b0;
    cmpl_data  = type_q[TYPE_WRITE] ? wdata_q : rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pj_ack != ACK_WAIT) err_d[ERR_ACK_IDLE] = 1'b1;
        if (pj_tv) begin
          cap_req = 1'b1;
          beats_d = (pj_size == SIZE_BURST) ? BURST_BEATS : 3'd1;
          wait_d  = '0;
          state_d = ST_BUSY;
          if (pj_type[TYPE_RSVD]) err_d[ERR_RSVD_TYPE] = 1'b1;
          if ((pj_size == SIZE_BURST) && pj_type[TYPE_WRITE]) err_d[ERR_BURST_WR] = 1'b1;
        end
      end
      ST_BUSY: begin
        // A request here, even alongside the final ack, is dropped.
        if (pj_tv) err_d[ERR_TV_BUSY] = 1'b1;
        if (pj_standby_out) err_d[ERR_STANDBY] = 1'b1;
        if (pj_ack == ACK_OK) begin
          if (!type_q[TYPE_WRITE]) begin
            cap_rd    = 1'b1;
            cmpl_data = pj_data_in;
          end
          beats_d = beats_q - 3'd1;
          if (beats_q == 3'd1) complete = 1'b1;
        end else if (is_err_ack(pj_ack)) begin
          complete   = 1'b1;
          cmpl_err   = 1'b1;
          errack_inc = 1'b1;
        end
        if (!complete) begin
          if (wait_q == WAIT_LAST) begin
            complete           = 1'b1;
            cmpl_err           = 1'b1;
            err_d[ERR_TIMEOUT] = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        if (complete) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request and read-beat capture; contents only matter while BUSY.
  always_ff @(posedge clk) begin
    if (cap_req) begin
      addr_q  <= pj_address;
      type_q  <= pj_type;
      size_q  <= pj_size;
      wdata_q <= pj_data_out;
      rdata_q <= '0;
    end else if (cap_rd) begin
      rdata_q <= pj_data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q  <= 1'b0;
      taddr_q <= '0;
      ttype_q <= '0;
      tsize_q <= '0;
      tdata_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      done_q <= complete;
      if (complete) begin
        taddr_q <= addr_q;
        ttype_q <= type_q;
        tsize_q <= size_q;
        tdata_q <= cmpl_data;
        terr_q  <= cmpl_err;
      end
    end
  end

  pj_sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (complete && !type_q[TYPE_WRITE]),
    .count_o (rd_count)
  );

  pj_sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (complete && type_q[TYPE_WRITE]),
    .count_o (wr_count)
  );

  pj_sat_counter #(.CNT_W(CNT_W)) u_errack_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (errack_inc),
    .count_o (errack_count)
  );

  assign txn_done  = done_q;
  assign txn_addr  = taddr_q;
  assign txn_type  = ttype_q;
  assign txn_size  = tsize_q;
  assign txn_data  = tdata_q;
  assign txn_err   = terr_q;
  assign err_flags = err_q;

endmodule

// File: tb/tb_pj_bus_monitor.sv
// Directed bench for pj_bus_monitor with hand-computed expectations
// (TIMEOUT=8, CNT_W=3 so timeout and counter saturation are reachable).
module tb_pj_bus_monitor;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             pj_tv;
  logic [3:0]       pj_type;
  logic [1:0]       pj_size;
  logic [1:0]       pj_ack;
  logic [29:0]      pj_address;
  logic [31:0]      pj_data_in;
  logic [31:0]      pj_data_out;
  logic             pj_standby_out;
  logic             txn_done;
  logic [29:0]      txn_addr;
  logic [3:0]       txn_type;
  logic [1:0]       txn_size;
  logic [31:0]      txn_data;
  logic             txn_err;
  logic [5:0]       err_flags;
  logic [CNT_W-1:0] rd_count, wr_count, errack_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pj_bus_monitor #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .pj_tv          (pj_tv),
    .pj_type        (pj_type),
    .pj_size        (pj_size),
    .pj_ack         (pj_ack),
    .pj_address     (pj_address),
    .pj_data_in     (pj_data_in),
    .pj_data_out    (pj_data_out),
    .pj_standby_out (pj_standby_out),
    .txn_done       (txn_done),
    .txn_addr       (txn_addr),
    .txn_type       (txn_type),
    .txn_size       (txn_size),
    .txn_data       (txn_data),
    .txn_err        (txn_err),
    .err_flags      (err_flags),
    .rd_count       (rd_count),
    .wr_count       (wr_count),
    .errack_count   (errack_count)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [29:0] a, input logic [3:0] t, input logic [1:0] s,
                         input logic [31:0] wd);
    pj_tv = 1'b1; pj_address = a; pj_type = t; pj_size = s; pj_data_out = wd;
    cyc();
    pj_tv = 1'b0; pj_data_out = '0;
  endtask

  task automatic quick_read(input logic [29:0] a, input logic [31:0] d);
    request(a, 4'b0000, 2'b10, 32'h0);
    pj_ack = 2'b01; pj_data_in = d;
    cyc();
    pj_ack = 2'b00; pj_data_in = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; pj_tv = 0; pj_type = 0; pj_size = 0; pj_ack = 0;
    pj_address = 0; pj_data_in = 0; pj_data_out = 0; pj_standby_out = 0;
    cyc(); cyc();
    chk_eq("rst_done", 32'(txn_done), 32'd0);
    chk_eq("rst_flags", 32'(err_flags), 32'd0);
    chk_eq("rst_rd", 32'(rd_count), 32'd0);
    chk_eq("rst_data", txn_data, 32'd0);
    reset = 1'b0;
    cyc();

    // Word read with one wait cycle
    request(30'h0000100, 4'b0000, 2'b10, 32'h0);
    cyc();
    chk_eq("rd_wait_done", 32'(txn_done), 32'd0);
    pj_ack = 2'b01; pj_data_in = 32'hDEADBEEF;
    cyc();
    pj_ack = 2'b00; pj_data_in = '0;
    chk_eq("rd_done", 32'(txn_done), 32'd1);
    chk_eq("rd_data", txn_data, 32'hDEADBEEF);
    chk_eq("rd_addr", 32'(txn_addr), 32'h100);
    chk_eq("rd_size", 32'(txn_size), 32'd2);
    chk_eq("rd_err", 32'(txn_err), 32'd0);
    chk_eq("rd_cnt", 32'(rd_count), 32'd1);
    chk_eq("rd_flags", 32'(err_flags), 32'd0);
    cyc();
    chk_eq("rd_pulse", 32'(txn_done), 32'd0);
    chk_eq("rd_hold", txn_data, 32'hDEADBEEF);

    // Burst read with a wait before every beat
    request(30'h0000200, 4'b0000, 2'b11, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      pj_ack = 2'b01; pj_data_in = 32'(i);
      cyc();
      pj_ack = 2'b00; pj_data_in = '0;
      if (i < 4) chk_eq("burst_early_done", 32'(txn_done), 32'd0);
    end
    chk_eq("burst_done", 32'(txn_done), 32'd1);
    chk_eq("burst_data", txn_data, 32'h4);
    chk_eq("burst_size", 32'(txn_size), 32'd3);
    chk_eq("burst_rd_cnt", 32'(rd_count), 32'd2);
    cyc();

    // Write ended by memory error
    request(30'h0000300, 4'b0001, 2'b10, 32'hA5A5A5A5);
    pj_ack = 2'b10;
    cyc();
    pj_ack = 2'b00;
    chk_eq("wrerr_done", 32'(txn_done), 32'd1);
    chk_eq("wrerr_err", 32'(txn_err), 32'd1);
    chk_eq("wrerr_data", txn_data, 32'hA5A5A5A5);
    chk_eq("wrerr_type", 32'(txn_type), 32'd1);
    chk_eq("wrerr_wr_cnt", 32'(wr_count), 32'd1);
    chk_eq("wrerr_errack", 32'(errack_count), 32'd1);
    chk_eq("wrerr_flags", 32'(err_flags), 32'd0);
    cyc();

    // Ack while idle
    pj_ack = 2'b01;
    cyc();
    pj_ack = 2'b00;
    chk_eq("ack_idle_flags", 32'(err_flags), 32'h02);
    chk_eq("ack_idle_done", 32'(txn_done), 32'd0);
    cyc();

    // Second tv while busy is ignored
    request(30'h0000400, 4'b0000, 2'b10, 32'h0);
    pj_tv = 1'b1; pj_address = 30'h00007FF;
    cyc();
    pj_tv = 1'b0;
    pj_ack = 2'b01; pj_data_in = 32'h11;
    cyc();
    pj_ack = 2'b00;
    chk_eq("tv_busy_flags", 32'(err_flags), 32'h03);
    chk_eq("tv_busy_addr", 32'(txn_addr), 32'h400);
    chk_eq("tv_busy_rd_cnt", 32'(rd_count), 32'd3);
    cyc();

    // Standby while busy
    request(30'h0000410, 4'b0000, 2'b10, 32'h0);
    pj_standby_out = 1'b1;
    cyc();
    pj_standby_out = 1'b0;
    pj_ack = 2'b01; pj_data_in = 32'h22;
    cyc();
    pj_ack = 2'b00;
    chk_eq("standby_flags", 32'(err_flags), 32'h23);
    chk_eq("standby_data", txn_data, 32'h22);
    cyc();

    // Burst write: flagged at request, still completes after four beats
    request(30'h0000500, 4'b0001, 2'b11, 32'h55);
    chk_eq("burstwr_flags", 32'(err_flags), 32'h33);
    pj_ack = 2'b01;
    cyc(); cyc(); cyc();
    chk_eq("burstwr_early", 32'(txn_done), 32'd0);
    cyc();
    pj_ack = 2'b00;
    chk_eq("burstwr_done", 32'(txn_done), 32'd1);
    chk_eq("burstwr_data", txn_data, 32'h55);
    chk_eq("burstwr_wr_cnt", 32'(wr_count), 32'd2);
    cyc();

    // Timeout with no ack
    request(30'h0000600, 4'b0000, 2'b10, 32'h0);
    k = 0;
    while (k < 20 && txn_done !== 1'b1) begin
      cyc();
      k++;
    end
    chk_eq("timeout_cycles", 32'(k), 32'd8);
    chk_eq("timeout_err", 32'(txn_err), 32'd1);
    chk_eq("timeout_addr", 32'(txn_addr), 32'h600);
    chk_eq("timeout_flags", 32'(err_flags), 32'h37);
    chk_eq("timeout_rd_cnt", 32'(rd_count), 32'd5);
    chk_eq("timeout_errack", 32'(errack_count), 32'd1);

    // Back to idle: further reads complete; read counter saturates at 7
    quick_read(30'h0000700, 32'h66);
    chk_eq("after_to_done", 32'(txn_done), 32'd1);
    chk_eq("after_to_err", 32'(txn_err), 32'd0);
    quick_read(30'h0000701, 32'h77);
    chk_eq("sat_rd_7", 32'(rd_count), 32'd7);
    quick_read(30'h0000702, 32'h88);
    chk_eq("sat_rd_hold", 32'(rd_count), 32'd7);
    chk_eq("sat_flags", 32'(err_flags), 32'h37);

    // Reset in the middle of a burst after two beats
    request(30'h0000800, 4'b0000, 2'b11, 32'h0);
    pj_ack = 2'b01; pj_data_in = 32'h1;
    cyc();
    pj_data_in = 32'h2;
    cyc();
    pj_ack = 2'b00; pj_data_in = '0;
    reset = 1'b1;
    #2;
    chk_eq("midrst_rd", 32'(rd_count), 32'd0);
    chk_eq("midrst_wr", 32'(wr_count), 32'd0);
    chk_eq("midrst_errack", 32'(errack_count), 32'd0);
    chk_eq("midrst_flags", 32'(err_flags), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    pj_ack = 2'b01; pj_data_in = 32'h3;
    cyc();
    pj_ack = 2'b00; pj_data_in = '0;
    chk_eq("midrst_no_done", 32'(txn_done), 32'd0);
    chk_eq("midrst_idle_flag", 32'(err_flags), 32'h02);
    cyc();
    quick_read(30'h0000123, 32'hCAFE0001);
    chk_eq("postrst_done", 32'(txn_done), 32'd1);
    chk_eq("postrst_data", txn_data, 32'hCAFE0001);
    chk_eq("postrst_addr", 32'(txn_addr), 32'h123);
    chk_eq("postrst_rd", 32'(rd_count), 32'd1);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pj_bus_monitor.md
# pj_bus_monitor

Synthesizable protocol checker and transaction recorder for the picoJava-II external memory bus (pj_* pins between core and BIU/memory model). It passively samples request, acknowledge and data signals. It flags protocol violations, reports each completed transaction, and keeps read/write/error counts. It drives nothing on the bus and sits beside the core in the system environment.

## Interface
- TIMEOUT, 256: maximum cycles from request to final acknowledge before timeout error (≥2).
- CNT_W, 16: width of each statistics counter.
- clk  in  1  bus clock (pj_clk); all sampling on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pj_tv  in  1  transfer valid; one-cycle request strobe.
- pj_type  in  4  [0]=write, [1]=instruction fetch, [2]=non-cacheable, [3]=reserved (must be 0).
- pj_size  in  2  00 byte, 01 halfword, 10 word, 11 four-word burst.
- pj_ack  in  2  00 wait, 01 ack, 10 memory error, 11 I/O error.
- pj_address  in  30  word address [31:2].
- pj_data_in  in  32  read data to core.
- pj_data_out  in  32  write data from core.
- pj_standby_out  in  1  core in standby.
- txn_done  out  1  one-cycle pulse: transaction completed.
- txn_addr  out  30  address of completed transaction.
- txn_type  out  4  type of completed transaction.
- txn_size  out  2  size of completed transaction.
- txn_data  out  32  last read beat or captured write data.
- txn_err  out  1  transaction ended with error ack.
- err_flags  out  6  sticky: [0] tv while busy, [1] ack while idle, [2] timeout, [3] reserved type bit, [4] burst write, [5] standby while busy.
- rd_count, wr_count, errack_count  out  CNT_W  saturating counters.

## Operation
- States: IDLE, BUSY. Reset: IDLE, all outputs 0, counters 0.
- IDLE with pj_tv=1: latch address, type, size, pj_data_out; beats_left = 4 if size=11 else 1; wait counter 0; go BUSY. Same cycle: pj_type[3]=1 sets err_flags[3]; size=11 with type[0]=1 sets err_flags[4].
- IDLE with pj_ack≠00 sets err_flags[1].
- BUSY:
  - pj_tv=1 sets err_flags[0]; the request is ignored.
  - pj_standby_out=1 sets err_flags[5].
  - ack=01: for reads, capture pj_data_in. Decrement beats_left. Reaching 0 completes the transaction.
  - ack=10/11: completes immediately with txn_err=1, whatever beats remain. Increments errack_count.
  - Wait counter increments on every BUSY cycle without completion. Reaching TIMEOUT sets err_flags[2], forces completion with txn_err=1, and returns to IDLE.
- Completion: txn_done pulses, txn_* hold until the next completion, and rd_count or wr_count increments per type[0] (error or not). Counters saturate at all-ones.
- err_flags are sticky until reset.
- A pj_tv coincident with final ack, in the same cycle, is a violation: err_flags[0] is set and the request is ignored.

## Timing
- Single-beat minimum: tv at cycle N, ack at N+1 or later. The ack cycle is edge E. txn_done and txn_* are registered and valid the cycle after E.
- A new pj_tv is legal the cycle after the final ack.
- Error flags and counters update at the clock edge after the offending or completing cycle.
- Burst: four ack=01 beats, any wait cycles between. txn_data = fourth beat.
- Reset asserted mid-transaction: returns to IDLE immediately. No txn_done is produced and counters clear.

## Structure
- Shared package pj_bus_pkg: size/ack/type-bit encodings, state enum, err_flags bit indices.
- Optional sub-module pj_sat_counter (CNT_W, saturating increment), instantiated three times.

## Test plan
- Word read: tv, addr=0x0000100, size=10, type=0000; ack=01 two cycles later with data 0xDEADBEEF. Required: txn_done one cycle after ack, txn_data=0xDEADBEEF, rd_count=1, err_flags=0.
- Burst read: size=11 with beats 0x1,0x2,0x3,0x4 and waits between. Required: one txn_done after fourth ack, txn_data=0x4, rd_count=1.
- Write with memory error: type=0001, data_out=0xA5A5A5A5, ack=10. Required: txn_err=1, txn_data=0xA5A5A5A5, wr_count=1, errack_count=1.
- Protocol violations:
  - ack=01 while idle sets err_flags[1].
  - Second tv while busy sets err_flags[0].
  - Standby while busy sets err_flags[5].
  - A burst write sets err_flags[4].
- Timeout: TIMEOUT=8, tv with no ack. Required: err_flags[2] set, txn_done with txn_err=1 about 8 cycles after tv, monitor back in IDLE.
- Reset mid-burst after two beats. Required: no txn_done, counters 0, next single read completes normally.
